stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control FSM that sequences the 4-digit BCD stopwatch counter from two debounced push-button levels. It drives the counter's `go` and `clr` inputs and reads back its digits. It also owns the display path: live time, frozen lap time, or final time. It detects counter wrap-around (9999 → 0000) and can optionally auto-stop on it. It sits between the button debouncers and the seven-segment display driver.

## Interface
- `AUTO_STOP`, default 1: 1 = on overflow, stop and hold 9999; 0 = flag only, keep counting.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  debounced button level; rising edge = start/stop command.
- `lap_clr`  in  1  debounced button level; rising edge = lap/clear command.
- `cnt_d3`..`cnt_d0`  in  4 each  live BCD digits from the counter (d3 = MSD).
- `go`  out  1  counter run enable.
- `clr`  out  1  counter clear.
- `disp_d3`..`disp_d0`  out  4 each  BCD digits to the display driver.
- `running`  out  1  high in RUN or LAP.
- `lap_active`  out  1  high in LAP.
- `ovf`  out  1  sticky overflow flag.

## Operation
- **Edge detect:** one register per button holds the previous level. Pulse = level & ~prev.
  - Reset loads prev = 1, so a button held through reset fires no pulse until it is released and pressed again.
- **States:** IDLE, RUN, LAP, STOP. `go`, `clr`, `running` and `lap_active` are decoded from the state register (Moore outputs).
  - IDLE: go=0, clr=1, disp=0000.
    - ss pulse → RUN.
    - lap pulse → stay in IDLE, ovf←0.
  - RUN: go=1, clr=0, disp=live cnt.
    - ss pulse → STOP, hold←cnt.
    - lap pulse → LAP, hold←cnt.
  - LAP: go=1, clr=0, disp=hold (frozen lap time; the counter keeps running).
    - lap pulse → RUN.
    - ss pulse → STOP, hold←current cnt (final time, not the lap time).
  - STOP: go=0, clr=1, disp=hold.
    - ss pulse → RUN; the count restarts from 0000 because the counter clears while go=0.
    - lap pulse → IDLE, hold←0000, ovf←0.
- **Simultaneous pulses:** ss wins and lap is discarded, in every state.
- **Overflow:** cnt_prev is a 16-bit register of the last sampled digits, updated every cycle.
  - In RUN or LAP, cnt_prev==9999 and cnt==0000 sets ovf=1.
  - If AUTO_STOP=1, overflow also forces → STOP with hold←9999. This applies even if an ss or lap pulse arrives the same cycle.
  - If AUTO_STOP=0, only ovf is set; the state is unchanged.
  - ovf is cleared only by reset or by a lap pulse in IDLE or STOP.
- **Digit handling:** digits are passed through unmodified; no BCD arithmetic is done in this block. Inputs above 9 are not checked.

## Timing
- **Reset values:** state=IDLE, hold=0000, cnt_prev=0000, prev levels=1, ovf=0.
  - Resulting outputs: go=0, clr=1, disp=0000, running=0, lap_active=0.
- **Command latency:** a button level first sampled high at edge N (low at N−1) changes state at edge N.
  - New go, clr and disp values are valid in the cycle after edge N.
- **hold capture:** loaded on the same edge as the state transition, from the cnt value present before that edge.
- **Live display:** disp follows cnt combinationally in RUN, with zero added latency.
- **Overflow detection:** one cycle after the counter wraps. On AUTO_STOP, go drops at the following edge; the counter may clear in that cycle, but disp shows 9999.
- **Reset mid-operation:** returns to IDLE on the next edge regardless of state or pending pulses. Buttons held high must be re-pressed.
- **Held button:** produces exactly one pulse per rising edge of the level.

## Test plan
- **Reset / held button:** reset with start_stop held high, then release reset → state stays IDLE, go=0, clr=1, disp=0000. Release and press start_stop → RUN, go=1.
- **Lap:** start, let the counter reach 0042, press lap_clr → disp frozen at 0042 while cnt advances to 0050. Press lap_clr → disp=0050 live.
- **Stop from LAP:** in LAP holding 0042 with cnt=0077, press start_stop → STOP, go=0, disp=0077. Press lap_clr → IDLE, disp=0000.
- **Simultaneous pulses:** in RUN with cnt=0123, raise both buttons in the same cycle → STOP, disp=0123, lap_active=0.
- **Overflow, AUTO_STOP=1:** drive cnt 9998→9999→0000 in RUN → ovf=1, STOP, disp=9999, go=0. Press lap_clr → ovf=0, IDLE.
- **Overflow, AUTO_STOP=0:** same wrap → ovf=1, state remains RUN, disp=0000 live, go=1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the 4-digit BCD stopwatch: turns button edges into counter go/clr,
// selects live/lap/final time for the display and flags counter wrap-around.
module stopwatch_ctrl #(
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap_clr,
  input  logic [3:0] cnt_d3,
  input  logic [3:0] cnt_d2,
  input  logic [3:0] cnt_d1,
  input  logic [3:0] cnt_d0,
  output logic       go,
  output logic       clr,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] cnt_prev_q;
  logic        ss_prev_q, lap_prev_q;
  logic        ovf_q, ovf_d;

  logic [15:0] cnt;
  logic [15:0] disp;
  logic        ss_pulse, lap_pulse, wrap;

  assign cnt       = {cnt_d3, cnt_d2, cnt_d1, cnt_d0};
  assign ss_pulse  = start_stop & ~ss_prev_q;
  assign lap_pulse = lap_clr & ~lap_prev_q;
  assign wrap      = ((state_q == StRun) || (state_q == StLap)) &&
                     (cnt_prev_q == 16'h9999) && (cnt == 16'h0000);

  // Previous levels reset high so a button held through reset must be re-pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_q     <= 16'h0000;
      cnt_prev_q <= 16'h0000;
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_prev_q <= cnt;
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap_clr;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (ss_pulse)       state_d = StRun;
        else if (lap_pulse) ovf_d   = 1'b0;
      end
      StRun: begin
        if (ss_pulse) begin
          state_d = StStop;
          hold_d  = cnt;
        end else if (lap_pulse) begin
          state_d = StLap;
          hold_d  = cnt;
        end
      end
      StLap: begin
        if (ss_pulse) begin
          state_d = StStop;
          hold_d  = cnt;
        end else if (lap_pulse) begin
          state_d = StRun;
        end
      end
      StStop: begin
        if (ss_pulse) begin
          state_d = StRun;
        end else if (lap_pulse) begin
          state_d = StIdle;
          hold_d  = 16'h0000;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Overflow overrides any button command in the same cycle.
    if (wrap) begin
      ovf_d = 1'b1;
      if (AUTO_STOP) begin
        state_d = StStop;
        hold_d  = 16'h9999;
      end
    end
  end

  always_comb begin
    go         = 1'b0;
    clr        = 1'b1;
    running    = 1'b0;
    lap_active = 1'b0;
    disp       = 16'h0000;
    case (state_q)
      StIdle: disp = 16'h0000;
      StRun: begin
        go      = 1'b1;
        clr     = 1'b0;
        running = 1'b1;
        disp    = cnt;
      end
      StLap: begin
        go         = 1'b1;
        clr        = 1'b0;
        running    = 1'b1;
        lap_active = 1'b1;
        disp       = hold_q;
      end
      StStop: disp = hold_q;
      default: disp = 16'h0000;
    endcase
  end

  assign disp_d3 = disp[15:12];
  assign disp_d2 = disp[11:8];
  assign disp_d1 = disp[7:4];
  assign disp_d0 = disp[3:0];
  assign ovf     = ovf_q;

endmodule
